// File: rtl/apb_pkg.sv
// Shared types and sizing for the APB register slave.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF      = 8;
  localparam int unsigned DATA_W_DEF      = 8;
  localparam int unsigned DEPTH_DEF       = 16;
  localparam int unsigned WAIT_CYCLES_DEF = 2;
  localparam int unsigned WAIT_W          = $clog2(16);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_e;

endpackage

// File: rtl/apb_wait_counter.sv
// Wait-state down-counter: load a count, decrement, flag when one cycle remains.
// done_o is registered and asserts in the cycle where the count equals 1.
module apb_wait_counter
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic              dec_i,
  input  logic              clr_i,
  output logic              done_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;

  // Next count: clear has priority over load, load over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_W'(1);
    end
    done_d = (cnt_d == WAIT_W'(1));
  end

  // Count and done flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a DEPTH x DATA_W register bank and WAIT_CYCLES wait states.
// Optional: define APB_SLAVE_PSLVERR_EN to flag out-of-range addresses via pslverr;
// otherwise addresses wrap modulo DEPTH and pslverr stays 0.
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic              pclk,
  input  logic              prstn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  state_e            state_q, state_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;

  logic [IDX_W-1:0]  addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;

  logic [DATA_W-1:0] bank_q [DEPTH];

  logic              setup_c;
  logic              bus_err_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rd_data_c;
  logic              cap_en_c;
  logic              wr_en_c;
  logic              cnt_load_c;
  logic              cnt_dec_c;
  logic              cnt_clr_c;
  logic              cnt_done;

  // Decode of the live bus address, used only at the setup edge.
  always_comb begin
    setup_c   = psel && !penable;
    bus_err_c = ERR_EN && (32'(paddr) >= DEPTH);
    if (ERR_EN) begin
      idx_c = IDX_W'(paddr);
    end else begin
      idx_c = IDX_W'(32'(paddr) % DEPTH);
    end
    rd_data_c = bus_err_c ? '0 : bank_q[idx_c];
  end

  apb_wait_counter u_wait_counter (
    .clk        (pclk),
    .rst_n      (prstn),
    .load_i     (cnt_load_c),
    .load_val_i (WAIT_W'(WAIT_CYCLES)),
    .dec_i      (cnt_dec_c),
    .clr_i      (cnt_clr_c),
    .done_o     (cnt_done)
  );

  // FSM state register.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    pready_d   = pready_q;
    pslverr_d  = pslverr_q;
    prdata_d   = prdata_q;
    cap_en_c   = 1'b0;
    wr_en_c    = 1'b0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    cnt_clr_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pready_d  = 1'b1;
        pslverr_d = 1'b0;
        if (setup_c) begin
          cap_en_c = 1'b1;
          if (!pwrite) begin
            prdata_d = rd_data_c;
          end
          if (WAIT_CYCLES == 0) begin
            state_d   = S_ACC;
            pslverr_d = bus_err_c;
          end else begin
            state_d    = S_WAIT;
            pready_d   = 1'b0;
            cnt_load_c = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d   = S_IDLE;
          pready_d  = 1'b1;
          cnt_clr_c = 1'b1;
        end else begin
          cnt_dec_c = 1'b1;
          if (cnt_done) begin
            state_d   = S_ACC;
            pready_d  = 1'b1;
            pslverr_d = err_q;
          end
        end
      end
      S_ACC: begin
        if (!psel) begin
          state_d   = S_IDLE;
          pready_d  = 1'b1;
          pslverr_d = 1'b0;
        end else if (penable && pready_q) begin
          wr_en_c   = wr_q && !err_q;
          state_d   = S_IDLE;
          pslverr_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        pready_d  = 1'b1;
        pslverr_d = 1'b0;
        cnt_clr_c = 1'b1;
      end
    endcase
  end

  // Registered bus outputs.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      pready_q  <= 1'b1;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Transfer fields captured at setup and frozen until completion.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (cap_en_c) begin
      addr_q  <= idx_c;
      wr_q    <= pwrite;
      wdata_q <= pwdata;
      err_q   <= bus_err_c;
    end
  end

  // Register bank, written at the completion edge of a write.
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (wr_en_c) begin
      bank_q[addr_q] <= wdata_q;
    end
  end

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: instance 0 has 2 wait states, instance 1 is zero-wait.
// Expectations follow APB_SLAVE_PSLVERR_EN when it is defined for the build.
module tb_apb_reg_slave;

`ifdef APB_SLAVE_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       prstn;
  logic       psel_s    [2];
  logic       penable_s [2];
  logic       pwrite_s  [2];
  logic [7:0] paddr_s   [2];
  logic [7:0] pwdata_s  [2];
  logic       pready_s  [2];
  logic [7:0] prdata_s  [2];
  logic       pslverr_s [2];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] rd;
  int         wt;
  logic       er;

  apb_reg_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)) u_dut_w2 (
    .pclk    (clk),
    .prstn   (prstn),
    .psel    (psel_s[0]),
    .penable (penable_s[0]),
    .pwrite  (pwrite_s[0]),
    .paddr   (paddr_s[0]),
    .pwdata  (pwdata_s[0]),
    .pready  (pready_s[0]),
    .prdata  (prdata_s[0]),
    .pslverr (pslverr_s[0])
  );

  apb_reg_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_w0 (
    .pclk    (clk),
    .prstn   (prstn),
    .psel    (psel_s[1]),
    .penable (penable_s[1]),
    .pwrite  (pwrite_s[1]),
    .paddr   (paddr_s[1]),
    .pwdata  (pwdata_s[1]),
    .pready  (pready_s[1]),
    .prdata  (prdata_s[1]),
    .pslverr (pslverr_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transfer on instance d; ends just after the completion edge.
  task automatic apb_xfer(input int d, input bit wr, input logic [7:0] addr,
                          input logic [7:0] wdata, output logic [7:0] rdata,
                          output int waits, output logic err);
    bit got_ready;
    @(negedge clk);
    psel_s[d]    = 1'b1;
    penable_s[d] = 1'b0;
    pwrite_s[d]  = wr;
    paddr_s[d]   = addr;
    pwdata_s[d]  = wdata;
    @(negedge clk);
    penable_s[d] = 1'b1;
    waits     = 0;
    got_ready = 1'b0;
    for (int n = 0; n < 32 && !got_ready; n++) begin
      if (pready_s[d]) begin
        got_ready = 1'b1;
      end else begin
        waits++;
        @(negedge clk);
      end
    end
    if (!got_ready) check_eq("pready_timeout", 32'(pready_s[d]), 32'd1);
    rdata = prdata_s[d];
    err   = pslverr_s[d];
    @(posedge clk);
  endtask

  task automatic bus_idle(input int d);
    @(negedge clk);
    psel_s[d]    = 1'b0;
    penable_s[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    prstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel_s[d] = 1'b0; penable_s[d] = 1'b0; pwrite_s[d] = 1'b0;
      paddr_s[d] = '0;  pwdata_s[d] = '0;
    end
    repeat (3) @(negedge clk);
    prstn = 1'b1;

    // Reset with a filled bank.
    for (int i = 0; i < 16; i++) apb_xfer(0, 1'b1, 8'(i), 8'(8'h10 + i), rd, wt, er);
    apb_xfer(0, 1'b0, 8'h05, 8'h00, rd, wt, er);
    check_eq("fill_rd05", 32'(rd), 32'h15);
    bus_idle(0);
    @(negedge clk);
    prstn = 1'b0;
    #1;
    check_eq("rst_pready_w2", 32'(pready_s[0]), 32'd1);
    check_eq("rst_prdata_w2", 32'(prdata_s[0]), 32'h00);
    check_eq("rst_pslverr_w2", 32'(pslverr_s[0]), 32'd0);
    check_eq("rst_pready_w0", 32'(pready_s[1]), 32'd1);
    @(negedge clk);
    prstn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      apb_xfer(0, 1'b0, 8'(i), 8'h00, rd, wt, er);
      check_eq($sformatf("rst_bank%0d", i), 32'(rd), 32'h00);
    end
    check_eq("rst_rd_waits", 32'(wt), 32'd2);
    bus_idle(0);

    // Two-wait write then read.
    apb_xfer(0, 1'b1, 8'h05, 8'hA5, rd, wt, er);
    check_eq("w2_wr_waits", 32'(wt), 32'd2);
    apb_xfer(0, 1'b0, 8'h05, 8'h00, rd, wt, er);
    check_eq("w2_rd_waits", 32'(wt), 32'd2);
    check_eq("w2_rd_data", 32'(rd), 32'hA5);
    check_eq("w2_rd_err", 32'(er), 32'd0);
    bus_idle(0);
    @(negedge clk);
    check_eq("w2_prdata_held", 32'(prdata_s[0]), 32'hA5);

    // Zero-wait back-to-back write then read.
    apb_xfer(1, 1'b1, 8'h03, 8'h3C, rd, wt, er);
    check_eq("w0_wr_waits", 32'(wt), 32'd0);
    apb_xfer(1, 1'b0, 8'h03, 8'h00, rd, wt, er);
    check_eq("w0_rd_waits", 32'(wt), 32'd0);
    check_eq("w0_rd_data", 32'(rd), 32'h3C);
    bus_idle(1);

    // Stray access phase from idle must not write.
    @(negedge clk);
    psel_s[1] = 1'b1; penable_s[1] = 1'b1; pwrite_s[1] = 1'b1;
    paddr_s[1] = 8'h03; pwdata_s[1] = 8'hEE;
    @(negedge clk);
    bus_idle(1);
    apb_xfer(1, 1'b0, 8'h03, 8'h00, rd, wt, er);
    check_eq("stray_rd_data", 32'(rd), 32'h3C);
    bus_idle(1);

    // Abort during wait states.
    apb_xfer(0, 1'b1, 8'h07, 8'h11, rd, wt, er);
    bus_idle(0);
    @(negedge clk);
    psel_s[0] = 1'b1; penable_s[0] = 1'b0; pwrite_s[0] = 1'b1;
    paddr_s[0] = 8'h07; pwdata_s[0] = 8'hFF;
    @(negedge clk);
    penable_s[0] = 1'b1;
    check_eq("abort_in_wait", 32'(pready_s[0]), 32'd0);
    @(negedge clk);
    psel_s[0] = 1'b0; penable_s[0] = 1'b0;
    @(negedge clk);
    check_eq("abort_pready", 32'(pready_s[0]), 32'd1);
    apb_xfer(0, 1'b0, 8'h07, 8'h00, rd, wt, er);
    check_eq("abort_rd_data", 32'(rd), 32'h11);
    bus_idle(0);

    // Out-of-range address.
    apb_xfer(0, 1'b1, 8'h00, 8'h12, rd, wt, er);
    apb_xfer(0, 1'b1, 8'h20, 8'h77, rd, wt, er);
    check_eq("oor_wr_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    check_eq("oor_wr_waits", 32'(wt), 32'd2);
    bus_idle(0);
    check_eq("oor_err_cleared", 32'(pslverr_s[0]), 32'd0);
    apb_xfer(0, 1'b0, 8'h00, 8'h00, rd, wt, er);
    check_eq("oor_rd00", 32'(rd), ERR_EN ? 32'h12 : 32'h77);
    apb_xfer(0, 1'b0, 8'h20, 8'h00, rd, wt, er);
    check_eq("oor_rd20_data", 32'(rd), ERR_EN ? 32'h00 : 32'h77);
    check_eq("oor_rd20_err", 32'(er), ERR_EN ? 32'd1 : 32'd0);
    bus_idle(0);

    // Asynchronous reset while waiting on a read of 0x05.
    @(negedge clk);
    psel_s[0] = 1'b1; penable_s[0] = 1'b0; pwrite_s[0] = 1'b0; paddr_s[0] = 8'h05;
    @(negedge clk);
    penable_s[0] = 1'b1;
    check_eq("midrst_pre_prdata", 32'(prdata_s[0]), 32'hA5);
    prstn = 1'b0;
    #1;
    check_eq("midrst_pready", 32'(pready_s[0]), 32'd1);
    check_eq("midrst_prdata", 32'(prdata_s[0]), 32'h00);
    @(negedge clk);
    prstn = 1'b1;
    psel_s[0] = 1'b0; penable_s[0] = 1'b0;
    apb_xfer(0, 1'b1, 8'h09, 8'h5A, rd, wt, er);
    check_eq("postrst_wr_waits", 32'(wt), 32'd2);
    apb_xfer(0, 1'b0, 8'h09, 8'h00, rd, wt, er);
    check_eq("postrst_rd09", 32'(rd), 32'h5A);
    apb_xfer(0, 1'b0, 8'h05, 8'h00, rd, wt, er);
    check_eq("postrst_rd05", 32'(rd), 32'h00);
    bus_idle(0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
